// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer controller for an asynchronous-style FIFO.
// Ports: clk_i/rst_i (sync active-high), rd_en_i, wr_gray_i/wr_msb_i in;
//        rd_addr_o, rd_gray_o/rd_msb_o, empty_o, count_o, underflow_o out.
module fifo_rd_ptr_ctrl #(
    parameter int Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_en_i,
    input  logic [Width-1:0] wr_gray_i,
    input  logic             wr_msb_i,
    output logic [Width-1:0] rd_addr_o,
    output logic [Width-1:0] rd_gray_o,
    output logic             rd_msb_o,
    output logic             empty_o,
    output logic [Width:0]   count_o,
    output logic             underflow_o
);

    localparam logic [Width:0] PTR_ONE = {{Width{1'b0}}, 1'b1};

    // {msb, gray} forms one reflected Gray code word of Width+1 bits.
    function automatic logic [Width:0] gray2bin(input logic [Width:0] g);
        logic [Width:0] b;
        b[Width] = g[Width];
        for (int i = Width - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [Width:0] bin2gray(input logic [Width:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [Width:0] sync1;
    logic [Width:0] sync2;
    logic [Width:0] wr_bin;
    logic [Width:0] rd_ptr_bin;
    logic [Width:0] rd_next;
    logic [Width:0] rd_gray_q;
    logic           accepted;

    assign wr_bin   = gray2bin(sync2);
    assign accepted = rd_en_i && !empty_o;
    assign rd_next  = accepted ? rd_ptr_bin + PTR_ONE : rd_ptr_bin;

    assign rd_addr_o = rd_ptr_bin[Width-1:0];
    assign rd_gray_o = rd_gray_q[Width-1:0];
    assign rd_msb_o  = rd_gray_q[Width];

    // Two-flop synchronizer; only the second stage is ever decoded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {wr_msb_i, wr_gray_i};
            sync2 <= sync1;
        end
    end

    // Flags are computed from the next pointer so they line up with
    // rd_addr_o on the same edge. A stale wr_bin can only make the
    // FIFO look emptier than it is, never falsely non-empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_bin  <= '0;
            rd_gray_q   <= '0;
            empty_o     <= 1'b1;
            count_o     <= '0;
            underflow_o <= 1'b0;
        end else begin
            rd_ptr_bin  <= rd_next;
            rd_gray_q   <= bin2gray(rd_next);
            empty_o     <= (rd_next == wr_bin);
            count_o     <= wr_bin - rd_next;
            underflow_o <= rd_en_i && empty_o;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed testbench for fifo_rd_ptr_ctrl (Width=3).
// Each task drives one scenario and checks hand-computed values inline.
module tb_fifo_rd_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic [3:0] wp;
    logic [2:0] rd_addr;
    logic [2:0] rd_gray;
    logic       rd_msb;
    logic       empty;
    logic [3:0] count;
    logic       underflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fifo_rd_ptr_ctrl #(.Width(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_en_i    (rd_en),
        .wr_gray_i  (wp[2:0]),
        .wr_msb_i   (wp[3]),
        .rd_addr_o  (rd_addr),
        .rd_gray_o  (rd_gray),
        .rd_msb_o   (rd_msb),
        .empty_o    (empty),
        .count_o    (count),
        .underflow_o(underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b1; wp = 4'b0000;
        step();
        total_cnt++;
        if ({empty, count, rd_addr, rd_msb, rd_gray, underflow} !== 13'b1_0000_000_0000_0)
            $display("FAIL reset_state got e=%b c=%0d a=%0d p=%b%b u=%b want 1 0 0 0000 0",
                     empty, count, rd_addr, rd_msb, rd_gray, underflow);
        else pass_cnt++;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if ({underflow, empty, rd_addr, rd_msb, rd_gray} !== 9'b1_1_000_0000)
                $display("FAIL reset_underflow%0d got u=%b e=%b a=%0d p=%b%b want 1 1 0 0000",
                         i, underflow, empty, rd_addr, rd_msb, rd_gray);
            else pass_cnt++;
        end
        rd_en = 1'b0;
        step();
        total_cnt++;
        if (underflow !== 1'b0)
            $display("FAIL reset_uf_clear got %b want 0", underflow);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        wp = 4'b0110;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if ({empty, count} !== 5'b1_0000)
                $display("FAIL fill_early%0d got e=%b c=%0d want 1 0", i, empty, count);
            else pass_cnt++;
        end
        step();
        total_cnt++;
        if ({empty, count} !== 5'b0_0100)
            $display("FAIL fill_latency got e=%b c=%0d want 0 4", empty, count);
        else pass_cnt++;
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (rd_addr !== 3'(i + 1) || count !== 4'(3 - i) || empty !== (i == 3))
                $display("FAIL drain%0d got a=%0d c=%0d e=%b want %0d %0d %b",
                         i, rd_addr, count, empty, i + 1, 3 - i, i == 3);
            else pass_cnt++;
        end
        rd_en = 1'b0;
        total_cnt++;
        if ({rd_msb, rd_gray} !== 4'b0110)
            $display("FAIL drain_gray got %b%b want 0110", rd_msb, rd_gray);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [2:0] addr_exp [8] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic       msb_exp  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        wp = 4'b1010;
        step(); step(); step();
        total_cnt++;
        if ({empty, count} !== 5'b0_1000)
            $display("FAIL wrap_full got e=%b c=%0d want 0 8", empty, count);
        else pass_cnt++;
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total_cnt++;
            if (rd_addr !== addr_exp[i] || rd_msb !== msb_exp[i])
                $display("FAIL wrap_read%0d got a=%0d m=%b want %0d %b",
                         i, rd_addr, rd_msb, addr_exp[i], msb_exp[i]);
            else pass_cnt++;
        end
        rd_en = 1'b0;
        total_cnt++;
        if ({rd_msb, rd_gray, empty, count} !== 9'b1010_1_0000)
            $display("FAIL wrap_end got p=%b%b e=%b c=%0d want 1010 1 0",
                     rd_msb, rd_gray, empty, count);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        wp = 4'b1011;
        step(); step(); step();
        total_cnt++;
        if ({empty, count} !== 5'b0_0001)
            $display("FAIL simul_setup got e=%b c=%0d want 0 1", empty, count);
        else pass_cnt++;
        wp = 4'b1001;
        step(); step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        total_cnt++;
        if ({empty, count, rd_addr} !== 8'b0_0001_101)
            $display("FAIL simul_read got e=%b c=%0d a=%0d want 0 1 5", empty, count, rd_addr);
        else pass_cnt++;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        total_cnt++;
        if ({empty, count, rd_addr} !== 8'b1_0000_110)
            $display("FAIL simul_drain got e=%b c=%0d a=%0d want 1 0 6", empty, count, rd_addr);
        else pass_cnt++;
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if ({underflow, empty, count, rd_addr, rd_msb, rd_gray} !== 13'b1_1_0000_110_1001)
                $display("FAIL underflow%0d got u=%b e=%b c=%0d a=%0d p=%b%b want 1 1 0 6 1001",
                         i, underflow, empty, count, rd_addr, rd_msb, rd_gray);
            else pass_cnt++;
        end
        rd_en = 1'b0;
        step();
        total_cnt++;
        if ({underflow, rd_addr} !== 4'b0_110)
            $display("FAIL underflow_end got u=%b a=%0d want 0 6", underflow, rd_addr);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        wp = 4'b0011;
        step(); step(); step();
        rd_en = 1'b1;
        step(); step(); step(); step();
        rd_en = 1'b0;
        total_cnt++;
        if ({rd_addr, empty, rd_msb, rd_gray} !== 8'b010_1_0011)
            $display("FAIL mid_setup got a=%0d e=%b p=%b%b want 2 1 0011",
                     rd_addr, empty, rd_msb, rd_gray);
        else pass_cnt++;
        wp = 4'b0100;
        step(); step(); step();
        total_cnt++;
        if ({count, rd_addr, empty} !== 8'b0101_010_0)
            $display("FAIL mid_count got c=%0d a=%0d e=%b want 5 2 0", count, rd_addr, empty);
        else pass_cnt++;
        rst = 1'b1; rd_en = 1'b1;
        step();
        rst = 1'b0; rd_en = 1'b0;
        total_cnt++;
        if ({empty, count, rd_addr, rd_msb, rd_gray, underflow} !== 13'b1_0000_000_0000_0)
            $display("FAIL mid_reset got e=%b c=%0d a=%0d p=%b%b u=%b want 1 0 0 0000 0",
                     empty, count, rd_addr, rd_msb, rd_gray, underflow);
        else pass_cnt++;
        step(); step();
        total_cnt++;
        if ({empty, count} !== 5'b1_0000)
            $display("FAIL mid_reload_early got e=%b c=%0d want 1 0", empty, count);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({empty, count, rd_addr} !== 8'b0_0111_000)
            $display("FAIL mid_reload got e=%b c=%0d a=%0d want 0 7 0", empty, count, rd_addr);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wp = 4'b0000;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_underflow();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
